// File: rtl/im_log2_frac16_if.sv
`default_nettype none
// ============================================================================
// im_log2_frac16_if : request/result bundle for the fixed-point log2 unit
// Rev 1.0
// ============================================================================
interface im_log2_frac16_if #(
  parameter int FRAC_BITS = 8
);
  logic                   start;
  logic [15:0]            number;
  logic                   ready;
  logic                   done;
  logic [4+FRAC_BITS-1:0] result;
  logic                   zero_err;

  modport master (
    output start, number,
    input  ready, done, result, zero_err
  );

  modport slave (
    input  start, number,
    output ready, done, result, zero_err
  );
endinterface
`default_nettype wire

// File: rtl/im_log2_frac16.sv
`default_nettype none
// ============================================================================
// im_log2_frac16 : sequential log2 of a 16-bit unsigned integer, one fraction
//                  bit per clock by repeated squaring of the mantissa
// Rev 1.0
// ============================================================================

// Bit-length encoder: position of the highest set bit plus one, 0 for zero.
module im_log16 (
  input  logic [15:0] value,
  output logic [4:0]  bit_len
);
  always_comb begin
    bit_len = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (value[i]) bit_len = 5'(i + 1);
    end
  end
endmodule

module im_log2_frac16 #(
  parameter int FRAC_BITS = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  im_log2_frac16_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          m_q, m_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [3:0]           int_q, int_d;
  logic [FRAC_BITS-1:0] frac_q, frac_d;
  logic                 zero_err_q, zero_err_d;

  logic [4:0]           bl;
  logic [15:0]          m_norm;
  logic [31:0]          sq;
  logic                 ready;
  logic                 accept;
  logic                 sq_unused;

  im_log16 u_log16 (
    .value   (bus.number),
    .bit_len (bl)
  );

  assign ready     = (state_q != ITER);
  assign accept    = bus.start && ready;
  assign m_norm    = bus.number << (5'd16 - bl);
  assign sq        = 32'(m_q) * 32'(m_q);
  assign sq_unused = &{1'b0, sq[14:0]};

  assign bus.ready    = ready;
  assign bus.done     = (state_q == DONE);
  assign bus.result   = {int_q, frac_q};
  assign bus.zero_err = zero_err_q;

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    int_d      = int_q;
    frac_d     = frac_q;
    zero_err_d = zero_err_q;

    case (state_q)
      ITER: begin
        // Square in [1,4): top bit set means the square reached 2, renormalise by one.
        m_d    = sq[31] ? sq[31:16] : sq[30:15];
        frac_d = (frac_q << 1) | FRAC_BITS'(sq[31]);
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'(FRAC_BITS - 1)) state_d = DONE;
      end
      default: begin
        if (accept) begin
          m_d    = m_norm;
          cnt_d  = 5'd0;
          frac_d = '0;
          if (bl == 5'd0) begin
            zero_err_d = 1'b1;
            int_d      = 4'd0;
            state_d    = DONE;
          end else begin
            zero_err_d = 1'b0;
            int_d      = 4'(bl - 5'd1);
            state_d    = ITER;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      m_q        <= '0;
      cnt_q      <= '0;
      int_q      <= '0;
      frac_q     <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      int_q      <= int_d;
      frac_q     <= frac_d;
      zero_err_q <= zero_err_d;
    end
  end
endmodule
`default_nettype wire
